riser_mcu_responder: RTL

Responder end of the riser's punted-read request/acknowledge protocol. It watches the three request strobes raised by the riser address decoder (RTC, JOYDATA, POTGOR), looks up the requested byte in a 16-entry shadow register file, and drives that byte for the D[31:24] lane. It then raises the acknowledge line, which the decoder synchronises and converts into DSACK. The shadow register file is loaded by the host MCU over a mode-0 SPI slave port.

---
 rtl/riser_pkg.sv | 27 ++
 rtl/riser_spi_slave.sv | 89 ++++++++
 rtl/riser_mcu_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/riser_pkg.sv
// riser_pkg: shared FSM state, register index map and SPI frame constants for the riser MCU responder
package riser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SETUP,
        ST_ACK,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] IDX_JOY0H    = 4'd0;
    localparam logic [3:0] IDX_JOY0L    = 4'd1;
    localparam logic [3:0] IDX_JOY1H    = 4'd2;
    localparam logic [3:0] IDX_JOY1L    = 4'd3;
    localparam logic [3:0] IDX_POTGOR   = 4'd4;
    localparam logic [3:0] IDX_RTC_BASE = 4'd8;

    localparam logic [4:0] SPI_FRAME_LEN = 5'd16;
    localparam int         CMD_W_BIT     = 7;

    // RTC outranks JOYDATA, which outranks POTGOR
    function automatic logic [3:0] req_idx(input logic rtc, input logic joy, input logic [4:0] a);
        return rtc ? (IDX_RTC_BASE | {1'b0, a[4:2]}) : joy ? (IDX_JOY0H | {2'b00, a[2:1]}) : IDX_POTGOR;
    endfunction

endpackage

// File: rtl/riser_spi_slave.sv
// riser_spi_slave: mode-0 SPI slave loading the shadow register file; readback under RISER_SPI_READBACK_EN
module riser_spi_slave
    import riser_pkg::*;
(
    input  logic       CLKCPU_A,
    input  logic       RESET,
    input  logic       SPI_NSS,
    input  logic       SPI_CK,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
`ifdef RISER_SPI_READBACK_EN
    input  logic [7:0] status,
    output logic [3:0] rd_idx,
    input  logic [7:0] rd_data,
`endif
    output logic       wr_en,
    output logic [3:0] wr_idx,
    output logic [7:0] wr_data
);

    logic [1:0]  ck_sync, nss_sync, mosi_sync;
    logic        ck_d, sck_rise;
    logic [14:0] shift;
    logic [4:0]  cnt;

    assign sck_rise = ck_sync[1] & ~ck_d;

    // two-flop synchronisers for the asynchronous SPI pins, plus SCK history for edge detection
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            ck_sync   <= 2'b00;
            nss_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            ck_d      <= 1'b0;
        end else begin
            ck_sync   <= {ck_sync[0], SPI_CK};
            nss_sync  <= {nss_sync[0], SPI_NSS};
            mosi_sync <= {mosi_sync[0], SPI_MOSI};
            ck_d      <= ck_sync[1];
        end
    end

    // shift in MSB first; the 16th bit of a write frame fires a one-cycle strobe, extra bits are ignored
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            shift   <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_idx  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (nss_sync[1]) begin
                cnt <= '0;
            end else if (sck_rise && cnt != SPI_FRAME_LEN) begin
                shift   <= {shift[13:0], mosi_sync[1]};
                cnt     <= cnt + 5'd1;
                wr_en   <= (cnt == SPI_FRAME_LEN - 5'd1) & shift[CMD_W_BIT + 7];
                wr_idx  <= shift[10:7];
                wr_data <= {shift[6:0], mosi_sync[1]};
            end
        end
    end

`ifdef RISER_SPI_READBACK_EN
    logic       nss_d;
    logic [7:0] tx;

    assign rd_idx   = shift[3:0];
    assign SPI_MISO = tx[7];

    // status byte loads at select, the addressed register loads after the command byte, shifting on SCK fall
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            nss_d <= 1'b1;
            tx    <= '0;
        end else begin
            nss_d <= nss_sync[1];
            if (!nss_sync[1] && nss_d)
                tx <= status;
            else if (!nss_sync[1] && !ck_sync[1] && ck_d)
                tx <= (cnt == 5'd8) ? (shift[CMD_W_BIT] ? 8'h00 : rd_data) : {tx[6:0], 1'b0};
        end
    end
`else
    assign SPI_MISO = 1'b0;
`endif

endmodule

// File: rtl/riser_mcu_responder.sv
// riser_mcu_responder: punted-read responder serving a 16-byte shadow file; RISER_SPI_READBACK_EN enables SPI readback
module riser_mcu_responder
    import riser_pkg::*;
#(
    parameter int SETUP_CYCLES = 2
) (
    input  logic       CLKCPU_A,
    input  logic       RESET,
    input  logic       REQ_RTC,
    input  logic       REQ_JOY,
    input  logic       REQ_BTN,
    input  logic [4:0] A,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       INTSIG7,
    input  logic       SPI_NSS,
    input  logic       SPI_CK,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO
);

    logic [7:0] regfile [16];
    state_t     state;
    logic [2:0] req, req_d, svc;
    logic [3:0] idx, cnt, look_idx;
    logic       svc_live, wr_en;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;

    assign req      = {REQ_RTC, REQ_JOY, REQ_BTN};
    assign svc_live = |(req & svc);
    assign look_idx = req_idx(REQ_RTC, REQ_JOY, A);

`ifdef RISER_SPI_READBACK_EN
    logic [3:0] rd_idx;

    riser_spi_slave u_spi (
        .CLKCPU_A (CLKCPU_A),
        .RESET    (RESET),
        .SPI_NSS  (SPI_NSS),
        .SPI_CK   (SPI_CK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO),
        .status   ({state != ST_IDLE, REQ_RTC, REQ_JOY, REQ_BTN, idx}),
        .rd_idx   (rd_idx),
        .rd_data  (regfile[rd_idx]),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data)
    );
`else
    riser_spi_slave u_spi (
        .CLKCPU_A (CLKCPU_A),
        .RESET    (RESET),
        .SPI_NSS  (SPI_NSS),
        .SPI_CK   (SPI_CK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data)
    );
`endif

    // shadow register file, written only by the SPI strobe; a same-cycle lookup still sees the old byte
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) regfile[i] <= 8'h00;
        end else if (wr_en) begin
            regfile[wr_idx] <= wr_data;
        end
    end

    // request/acknowledge handshake; the request serviced is frozen in LOOKUP and alone governs release
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            state   <= ST_IDLE;
            req_d   <= '0;
            svc     <= '0;
            idx     <= '0;
            cnt     <= '0;
            D_OUT   <= 8'h00;
            D_OE    <= 1'b0;
            INTSIG7 <= 1'b0;
        end else begin
            req_d <= req;
            case (state)
                ST_IDLE: if (|(req & ~req_d)) state <= ST_LOOKUP;
                ST_LOOKUP: begin
                    if (!(|req)) begin
                        state <= ST_IDLE;
                    end else begin
                        idx   <= look_idx;
                        D_OUT <= regfile[look_idx];
                        svc   <= REQ_RTC ? 3'b100 : REQ_JOY ? 3'b010 : 3'b001;
                        cnt   <= '0;
                        D_OE  <= 1'b1;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!svc_live) begin
                        D_OE  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == 4'(SETUP_CYCLES - 1)) begin
                        INTSIG7 <= 1'b1;
                        state   <= ST_ACK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_ACK: begin
                    if (!svc_live) begin
                        INTSIG7 <= 1'b0;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    D_OE  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
